// File: rtl/dram_pkg.sv
// Shared types and constants for the dram_dma word-copy engine.
package dram_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;

    // Default legal RAM window (word addresses, both ends inclusive).
    localparam int DEF_MEM_LO = 8;
    localparam int DEF_MEM_HI = 2000;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dram_dma.sv
// Word-copy DMA engine: copies len words from src to dst, one RAM access per
// cycle (read cycle then write cycle per word), ascending addresses.
// Optional fill mode is compiled in with DRAM_DMA_FILL_EN: when enabled and
// fill=1 at start, every cycle writes fill_val to dst+count and no reads occur.
// All mem_* outputs are registered so the RAM's negedge write sees settled
// address and data.
module dram_dma
    import dram_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int MEM_LO = DEF_MEM_LO,
    parameter int MEM_HI = DEF_MEM_HI
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Range limits widened by one bit so base+len-1 cannot wrap silently.
    localparam logic [ADDR_W:0] LO_X  = (ADDR_W+1)'(MEM_LO);
    localparam logic [ADDR_W:0] HI_X  = (ADDR_W+1)'(MEM_HI);
    localparam logic [ADDR_W:0] ONE_X = (ADDR_W+1)'(1);

    dma_state_t        state_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] count_reg;
    logic              fill_reg;
    logic [DATA_W-1:0] fill_val_reg;

    logic [ADDR_W-1:0] count_next;
    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_end;
    logic              src_bad;
    logic              dst_bad;
    logic              fill_req;
    logic              range_err;

`ifdef DRAM_DMA_FILL_EN
    assign fill_req = fill;
`else
    // Fill mode not built: the fill request is ignored, copy mode always.
    logic unused_fill;
    assign fill_req    = 1'b0;
    assign unused_fill = fill;
`endif

    // Acceptance-time range check on the incoming descriptor (ADDR_W+1 bit sums).
    always_comb begin
        src_end   = {1'b0, src} + {1'b0, len} - ONE_X;
        dst_end   = {1'b0, dst} + {1'b0, len} - ONE_X;
        src_bad   = ({1'b0, src} < LO_X) || (src_end > HI_X);
        dst_bad   = ({1'b0, dst} < LO_X) || (dst_end > HI_X);
        // In fill mode the source is never read, so it is not checked.
        range_err = dst_bad || (src_bad && !fill_req);
    end

    assign count_next = count_reg + ADDR_W'(1);

    // Control FSM with registered outputs; mem_wdata doubles as the data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            src_reg      <= '0;
            dst_reg      <= '0;
            len_reg      <= '0;
            count_reg    <= '0;
            fill_reg     <= 1'b0;
            fill_val_reg <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_reg      <= src;
                        dst_reg      <= dst;
                        len_reg      <= len;
                        fill_reg     <= fill_req;
                        fill_val_reg <= fill_val;
                        count_reg    <= '0;
                        err          <= 1'b0;
                        if (len == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else if (range_err) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else if (fill_req) begin
                            state_reg <= WR;
                            busy      <= 1'b1;
                            mem_write <= 1'b1;
                            mem_addr  <= dst;
                            mem_wdata <= fill_val;
                        end else begin
                            state_reg <= RD;
                            busy      <= 1'b1;
                            mem_read  <= 1'b1;
                            mem_addr  <= src;
                        end
                    end
                end
                RD: begin
                    // Capture the word and present it for writing next cycle.
                    mem_wdata <= mem_rdata;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_addr  <= dst_reg + count_reg;
                    state_reg <= WR;
                end
                WR: begin
                    count_reg <= count_next;
                    if (count_next == len_reg) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_write <= 1'b0;
                    end else if (fill_reg) begin
                        mem_addr  <= dst_reg + count_next;
                        mem_wdata <= fill_val_reg;
                    end else begin
                        state_reg <= RD;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= src_reg + count_next;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_dma.sv
// Self-checking bench for dram_dma: a word RAM model with negedge writes and
// combinational reads, plus a reference copy of memory updated per command.
module tb_dram_dma;

`ifdef DRAM_DMA_FILL_EN
    localparam bit FILL_BUILD = 1'b1;
`else
    localparam bit FILL_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] src, dst, len;
    logic        fill;
    logic [15:0] fill_val;
    logic        busy, done, err, mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dram_dma #(.ADDR_W(16), .DATA_W(16), .MEM_LO(8), .MEM_HI(2000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
        .fill(fill), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [15:0] ram  [0:4095];
    logic [15:0] refm [0:4095];
    logic        init_req;
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int txn_id   = 0;

    function automatic logic [15:0] pat(int i);
        return 16'(i * 40503 + 7);
    endfunction

    // RAM model: bulk init, bench preload, and DUT writes commit on negedge.
    always @(negedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
        end else begin
            if (pre_we) ram[pre_addr] <= pre_data;
            if (mem_write && mem_addr < 16'd4096) ram[mem_addr[11:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? ram[mem_addr[11:0]] : 16'h0000;

    // Bus monitor: access counts, done pulses, read/write overlap, and
    // every read cycle being immediately followed by a write cycle.
    int   rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0, seq_bad = 0;
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (mem_read)              rd_cnt   <= rd_cnt + 1;
        if (mem_write)             wr_cnt   <= wr_cnt + 1;
        if (done)                  done_cnt <= done_cnt + 1;
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
        if (prev_rd && !mem_write && rst_n) seq_bad <= seq_bad + 1;
        prev_rd <= mem_read;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        #1;
        pre_addr = 12'(a);
        pre_data = d;
        pre_we   = 1'b1;
        refm[a]  = d;
        @(negedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== refm[i]) bad++;
        check(tag, bad, 0);
    endtask

    // One command: drive, time the done pulse, then compare against the model.
    task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           input logic f, input logic [15:0] fv, input bit interfere);
        int  k, r0, w0, d0, b0, q0, exp_k, exp_rd, exp_wr;
        bit  fm, exp_err, sbad, dbad, quiet;
        fm    = f && FILL_BUILD;
        sbad  = (int'(s) < 8) || (int'(s) + int'(l) - 1 > 2000);
        dbad  = (int'(d) < 8) || (int'(d) + int'(l) - 1 > 2000);
        exp_err = (l != 0) && (dbad || (sbad && !fm));
        quiet = exp_err || (l == 0);
        exp_k  = quiet ? 1 : (fm ? 1 + int'(l) : 1 + 2 * int'(l));
        exp_rd = (quiet || fm) ? 0 : int'(l);
        exp_wr = quiet ? 0 : int'(l);
        if (!quiet)
            for (int i = 0; i < int'(l); i++)
                refm[int'(d) + i] = fm ? fv : refm[int'(s) + i];

        #1;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; b0 = both_cnt; q0 = seq_bad;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l; fill = f; fill_val = fv;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check("busy_first_cycle", busy, !quiet);
        while (done !== 1'b1 && k < 200) begin
            if (interfere) begin
                start = (k == 2);
                src = 16'd1500; dst = 16'd1600; len = 16'd2;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_cycle", k, exp_k);
        check("err_at_done", err, exp_err);
        repeat (3) @(negedge clk);
        #1;
        check("read_count", rd_cnt - r0, exp_rd);
        check("write_count", wr_cnt - w0, exp_wr);
        check("done_pulses", done_cnt - d0, 1);
        check("rd_wr_overlap", both_cnt - b0, 0);
        check("rd_then_wr", seq_bad - q0, 0);
        check("err_sticky", err, exp_err);
        check("busy_idle", busy, 1'b0);
        mem_check("mem_contents");
        txn_id++;
        $display("txn %0d: src=%0d dst=%0d len=%0d fill=%0d done_at=T+%0d err=%0d",
                 txn_id, s, d, l, fm, k, err);
    endtask

    initial begin
        int s, d, l, sel;
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        fill = 1'b0; fill_val = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        init_req = 1'b1;
        for (int i = 0; i < 4096; i++) refm[i] = pat(i);
        @(negedge clk);
        #1 init_req = 1'b0;

        // Reset state.
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy with known data.
        poke(100, 16'h00A1); poke(101, 16'h00B2); poke(102, 16'h00C3); poke(103, 16'h00D4);
        run_cmd(16'd100, 16'd200, 16'd4, 1'b0, 16'h0, 1'b0);
        check("copy_word3", ram[203], 16'h00D4);

        // Zero length and range errors.
        run_cmd(16'd100, 16'd200, 16'd0, 1'b0, 16'h0, 1'b0);
        run_cmd(16'd1990, 16'd200, 16'd20, 1'b0, 16'h0, 1'b0);
        run_cmd(16'd4, 16'd200, 16'd2, 1'b0, 16'h0, 1'b0);
        run_cmd(16'd100, 16'hFFFF, 16'd2, 1'b0, 16'h0, 1'b0);
        run_cmd(16'd8, 16'd1997, 16'd4, 1'b0, 16'h0, 1'b0);
        run_cmd(16'd100, 16'd1998, 16'd4, 1'b0, 16'h0, 1'b0);

        // Start while busy must be ignored.
        run_cmd(16'd100, 16'd700, 16'd4, 1'b0, 16'h0, 1'b1);

        // Reset during the write cycle of word 2 (cycle T+6) of a 4-word copy.
        @(negedge clk);
        start = 1'b1; src = 16'd100; dst = 16'd600; len = 16'd4; fill = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_mem_write", mem_write, 1'b0);
        check("midrst_mem_read", mem_read, 1'b0);
        check("midrst_mem_addr", mem_addr, 16'h0);
        check("midrst_mem_wdata", mem_wdata, 16'h0);
        check("midrst_done", done, 1'b0);
        refm[600] = refm[100];
        refm[601] = refm[101];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 mem_check("midrst_mem");
        txn_id++;
        $display("txn %0d: src=100 dst=600 len=4 reset during word 2 write", txn_id);
        run_cmd(16'd120, 16'd800, 16'd3, 1'b0, 16'h0, 1'b0);

        // Fill requests (copy or fill depending on the build).
        run_cmd(16'd100, 16'd300, 16'd3, 1'b1, 16'h5A5A, 1'b0);
        run_cmd(16'd4, 16'd320, 16'd2, 1'b1, 16'hC0DE, 1'b0);

        // Overlapping forward copy and in-place copy.
        run_cmd(16'd500, 16'd502, 16'd6, 1'b0, 16'h0, 1'b0);
        run_cmd(16'd510, 16'd510, 16'd3, 1'b0, 16'h0, 1'b0);

        // Randomized commands.
        for (int t = 0; t < 12; t++) begin
            s   = int'($urandom_range(10, 1950));
            l   = int'($urandom_range(1, 10));
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       d = s + int'($urandom_range(1, 3));
                1:       d = s;
                2:       d = int'($urandom_range(8, 1990));
                3:       d = s - 2;
                default: begin d = int'($urandom_range(1990, 2000)); l = 12; end
            endcase
            run_cmd(16'(s), 16'(d), 16'(l), 1'($urandom_range(0, 3) == 0),
                    16'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
